wired_rob_retire: RTL and testbench

- Commit-side reader of the ROB.
- Drives the two ROB read IDs at the head, consumes per-slot completion and event flags, and decides per-cycle retirement of 0–2 instructions.
- On a backend event (exception, refetch or mispredict) it walks and retires every remaining allocated entry without architectural writeback, so rename state is restored. It then raises a one-cycle flush with a redirect PC.
- Sits between the ROB storage and the commit/ARF/rename-recovery logic.

---
 rtl/wired_rob_retire.sv | 162 ++++++++++++++++
 tb/tb_wired_rob_retire.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wired_rob_retire.sv
`default_nettype none
// ============================================================================
// wired_rob_retire : ROB commit-side reader. Retires 0-2 entries per cycle,
// walks the remaining entries after a backend event, then pulses a flush.
// Optional feature macro: WIRED_RETIRE_PERF_EN (retire/flush perf counters).
// Revision: 1.0
// ============================================================================
module wired_rob_retire #(
  parameter int ROB_LEN = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [1:0][ROB_LEN-1:0] c_rrrid_o,
  input  logic [1:0]              c_valid_i,
  input  logic [1:0]              c_excp_i,
  input  logic [1:0]              c_refetch_i,
  input  logic [1:0]              c_need_jump_i,
  input  logic [1:0][31:0]        c_pc_i,
  input  logic [1:0][31:0]        c_target_i,
  input  logic [31:0]             excp_entry_i,
  input  logic                    commit_stall_i,
  input  logic [ROB_LEN:0]        p_tail_i,
  output logic [1:0]              c_retire_o,
  output logic [1:0]              c_wb_en_o,
  output logic                    stall_dispatch_o,
  output logic                    flush_o,
  output logic                    redirect_o,
  output logic [31:0]             redirect_pc_o,
  output logic                    excp_o,
  output logic [31:0]             excp_pc_o
`ifdef WIRED_RETIRE_PERF_EN
  ,
  output logic [63:0]             perf_retired_o,
  output logic [31:0]             perf_flush_o
`endif
);

  localparam int PW = ROB_LEN + 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WALK  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] head_q, head_d, head_p1, remaining;
  logic [31:0]   redirect_q, redirect_d;
  logic [31:0]   excp_pc_q, excp_pc_d;
  logic          excp_q, excp_d;
  logic          stall_q;
  logic [1:0]    retire, wb_en;
  logic          ev0;
  logic          unused_pc1;

  // Slot 1 PC is never needed: slot-1 exceptions/refetches are deferred to slot 0.
  assign unused_pc1 = ^c_pc_i[1];

  assign ev0       = c_excp_i[0] | c_refetch_i[0] | c_need_jump_i[0];
  assign remaining = p_tail_i - head_q;
  assign head_p1   = head_q + PW'(1);

  assign c_rrrid_o[0] = head_q[ROB_LEN-1:0];
  assign c_rrrid_o[1] = head_p1[ROB_LEN-1:0];

  always_comb begin
    state_d    = state_q;
    retire     = 2'b00;
    wb_en      = 2'b00;
    redirect_d = redirect_q;
    excp_pc_d  = excp_pc_q;
    excp_d     = excp_q;
    case (state_q)
      S_RUN: begin
        retire[0] = c_valid_i[0] & ~commit_stall_i;
        retire[1] = retire[0] & ~ev0 & c_valid_i[1] & ~c_excp_i[1] & ~c_refetch_i[1];
        wb_en[0]  = retire[0] & ~c_excp_i[0] & ~c_refetch_i[0];
        wb_en[1]  = retire[1];
        if (retire[0] && ev0) begin
          state_d = S_WALK;
          excp_d  = c_excp_i[0];
          if (c_excp_i[0]) begin
            redirect_d = excp_entry_i;
            excp_pc_d  = c_pc_i[0];
          end else if (c_refetch_i[0]) begin
            redirect_d = c_pc_i[0];
          end else begin
            redirect_d = c_target_i[0];
          end
        end else if (retire[1] && c_need_jump_i[1]) begin
          state_d    = S_WALK;
          excp_d     = 1'b0;
          redirect_d = c_target_i[1];
        end
      end
      S_WALK: begin
        // Walk tracks the live tail so entries allocated in the event cycle are undone too.
        if (remaining == '0) begin
          state_d = S_FLUSH;
        end else if (remaining == PW'(1)) begin
          retire = 2'b01;
        end else begin
          retire = 2'b11;
        end
      end
      S_FLUSH: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
    head_d = head_q + PW'(retire[0]) + PW'(retire[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      head_q     <= '0;
      redirect_q <= '0;
      excp_pc_q  <= '0;
      excp_q     <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      redirect_q <= redirect_d;
      excp_pc_q  <= excp_pc_d;
      excp_q     <= excp_d;
      stall_q    <= (state_d != S_RUN);
    end
  end

  assign c_retire_o       = retire;
  assign c_wb_en_o        = wb_en;
  assign stall_dispatch_o = stall_q;
  assign flush_o          = (state_q == S_FLUSH);
  assign redirect_o       = (state_q == S_FLUSH);
  assign redirect_pc_o    = redirect_q;
  assign excp_o           = (state_q == S_FLUSH) & excp_q;
  assign excp_pc_o        = excp_pc_q;

`ifdef WIRED_RETIRE_PERF_EN
  logic [63:0] perf_retired_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired_q <= '0;
      perf_flush_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_q + 64'(wb_en[0]) + 64'(wb_en[1]);
      perf_flush_q   <= perf_flush_q + 32'(flush_o);
    end
  end

  assign perf_retired_o = perf_retired_q;
  assign perf_flush_o   = perf_flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wired_rob_retire.sv
`default_nettype none
// Bench for wired_rob_retire: a directed vector table on a ROB_LEN=6 instance,
// plus hand sequences for wrap/full walk (ROB_LEN=2 instance) and reset mid-walk.
module tb_wired_rob_retire;

  localparam int RL  = 6;
  localparam int RL2 = 2;
  localparam logic [31:0] EE = 32'h1C00_8000;
  localparam logic [31:0] T0 = 32'hDEAD_0000;
  localparam logic [31:0] JT = 32'h1C00_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        valid, excp, refetch, jump;
  logic [1:0][31:0]  pc, tgt;
  logic              stall;
  logic [RL:0]       tail;
  logic [RL2:0]      tail2;

  logic [1:0][RL-1:0]  rrrid;
  logic [1:0]          ret, wb;
  logic                sd, fl, rd, ex;
  logic [31:0]         rpc, epc;

  logic [1:0][RL2-1:0] rrrid2;
  logic [1:0]          ret2, wb2;
  logic                sd2, fl2, rd2, ex2;
  logic [31:0]         rpc2, epc2;

`ifdef WIRED_RETIRE_PERF_EN
  logic [63:0] pr, pr2;
  logic [31:0] pf, pf2;
`endif

  wired_rob_retire #(.ROB_LEN(RL)) dut (
    .clk(clk), .rst(rst), .c_rrrid_o(rrrid),
    .c_valid_i(valid), .c_excp_i(excp), .c_refetch_i(refetch), .c_need_jump_i(jump),
    .c_pc_i(pc), .c_target_i(tgt), .excp_entry_i(EE), .commit_stall_i(stall),
    .p_tail_i(tail), .c_retire_o(ret), .c_wb_en_o(wb), .stall_dispatch_o(sd),
    .flush_o(fl), .redirect_o(rd), .redirect_pc_o(rpc), .excp_o(ex), .excp_pc_o(epc)
`ifdef WIRED_RETIRE_PERF_EN
    , .perf_retired_o(pr), .perf_flush_o(pf)
`endif
  );

  wired_rob_retire #(.ROB_LEN(RL2)) dut2 (
    .clk(clk), .rst(rst), .c_rrrid_o(rrrid2),
    .c_valid_i(valid), .c_excp_i(excp), .c_refetch_i(refetch), .c_need_jump_i(jump),
    .c_pc_i(pc), .c_target_i(tgt), .excp_entry_i(EE), .commit_stall_i(stall),
    .p_tail_i(tail2), .c_retire_o(ret2), .c_wb_en_o(wb2), .stall_dispatch_o(sd2),
    .flush_o(fl2), .redirect_o(rd2), .redirect_pc_o(rpc2), .excp_o(ex2), .excp_pc_o(epc2)
`ifdef WIRED_RETIRE_PERF_EN
    , .perf_retired_o(pr2), .perf_flush_o(pf2)
`endif
  );

  typedef struct {
    logic [1:0]  valid, excp, refetch, jump;
    logic        stall;
    logic [6:0]  tail;
    logic [31:0] pc0, tgt0, tgt1;
    logic [5:0]  id0;
    logic [1:0]  ret, wb;
    logic        sd, fl;
    logic [31:0] rpc;
    logic        ex;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic [1:0] va, input logic [1:0] e, input logic [1:0] rf,
                              input logic [1:0] jp, input logic st, input logic [6:0] tl,
                              input logic [31:0] p0, input logic [31:0] t0, input logic [31:0] t1,
                              input logic [5:0] id, input logic [1:0] rt, input logic [1:0] w,
                              input logic s, input logic f, input logic [31:0] rp,
                              input logic x, input logic [31:0] ep);
    vec_t v;
    v.valid = va; v.excp = e; v.refetch = rf; v.jump = jp; v.stall = st; v.tail = tl;
    v.pc0 = p0; v.tgt0 = t0; v.tgt1 = t1;
    v.id0 = id; v.ret = rt; v.wb = w; v.sd = s; v.fl = f; v.rpc = rp; v.ex = x; v.epc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] va, input logic [1:0] e, input logic [1:0] rf,
                       input logic [1:0] jp, input logic st, input logic [31:0] p0,
                       input logic [31:0] t0, input logic [31:0] t1);
    valid = va; excp = e; refetch = rf; jump = jp; stall = st;
    pc[0] = p0; pc[1] = p0 + 32'd4; tgt[0] = t0; tgt[1] = t1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h1000, T0, 32'h0);
    tail = '0; tail2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Vector table: one row per cycle, expectations hand-derived from the head pointer.
    //             valid  excp   refch  jump   st tail  pc0       tgt0 tgt1 | id0 ret    wb     sd fl rpc ex epc
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 7'd0,  32'h1000, T0, 0,  6'd0,  2'b00, 2'b00, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 0, 7'd0,  32'h1000, T0, 0,  6'd0,  2'b11, 2'b11, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 0, 7'd0,  32'h1000, T0, 0,  6'd2,  2'b11, 2'b11, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2'b00, 0, 7'd0,  32'h1000, T0, 0,  6'd4,  2'b01, 2'b01, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 0, 7'd0,  32'h1000, T0, 0,  6'd5,  2'b11, 2'b11, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 0, 7'd0,  32'h1000, T0, 0,  6'd7,  2'b11, 2'b11, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 0, 7'd0,  32'h1000, T0, 0,  6'd9,  2'b11, 2'b11, 0, 0, 0,  0, 0));
    // slot-1 exception is held back, then taken at slot 0
    tbl.push_back(mk(2'b11, 2'b10, 2'b00, 2'b00, 0, 7'd0,  32'h0100, T0, 0,  6'd11, 2'b01, 2'b01, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 0, 7'd17, 32'h0104, T0, 0,  6'd12, 2'b01, 2'b00, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 7'd17, 32'h1000, T0, 0,  6'd13, 2'b11, 2'b00, 1, 0, 0,  0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 7'd17, 32'h1000, T0, 0,  6'd15, 2'b11, 2'b00, 1, 0, 0,  0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 7'd17, 32'h1000, T0, 0,  6'd17, 2'b00, 2'b00, 1, 0, 0,  0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 7'd17, 32'h1000, T0, 0,  6'd17, 2'b00, 2'b00, 1, 1, EE, 1, 32'h0104));
    // slot-1 mispredict with empty remainder
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b10, 0, 7'd19, 32'h1000, T0, JT, 6'd17, 2'b11, 2'b11, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 7'd19, 32'h1000, T0, 0,  6'd19, 2'b00, 2'b00, 1, 0, 0,  0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 7'd19, 32'h1000, T0, 0,  6'd19, 2'b00, 2'b00, 1, 1, JT, 0, 0));
    // head refetch under commit stall
    tbl.push_back(mk(2'b01, 2'b00, 2'b01, 2'b00, 1, 7'd20, 32'h0200, T0, 0,  6'd19, 2'b00, 2'b00, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b01, 2'b00, 2'b01, 2'b00, 1, 7'd20, 32'h0200, T0, 0,  6'd19, 2'b00, 2'b00, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b01, 2'b00, 2'b01, 2'b00, 1, 7'd20, 32'h0200, T0, 0,  6'd19, 2'b00, 2'b00, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b01, 2'b00, 2'b01, 2'b00, 0, 7'd20, 32'h0200, T0, 0,  6'd19, 2'b01, 2'b00, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 7'd20, 32'h1000, T0, 0,  6'd20, 2'b00, 2'b00, 1, 0, 0,  0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 7'd20, 32'h1000, T0, 0,  6'd20, 2'b00, 2'b00, 1, 1, 32'h0200, 0, 0));
    // clean stall, then slot-0 mispredict (writes back, blocks slot 1)
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 1, 7'd20, 32'h1000, T0, 0,  6'd20, 2'b00, 2'b00, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b01, 0, 7'd21, 32'h1000, T0, 0,  6'd20, 2'b01, 2'b01, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 7'd21, 32'h1000, T0, 0,  6'd21, 2'b00, 2'b00, 1, 0, 0,  0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 7'd21, 32'h1000, T0, 0,  6'd21, 2'b00, 2'b00, 1, 1, T0, 0, 0));
    // exception outranks refetch on the same entry
    tbl.push_back(mk(2'b01, 2'b01, 2'b01, 2'b00, 0, 7'd22, 32'h0300, T0, 0,  6'd21, 2'b01, 2'b00, 0, 0, 0,  0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 7'd22, 32'h1000, T0, 0,  6'd22, 2'b00, 2'b00, 1, 0, 0,  0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 7'd22, 32'h1000, T0, 0,  6'd22, 2'b00, 2'b00, 1, 1, EE, 1, 32'h0300));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 7'd22, 32'h1000, T0, 0,  6'd22, 2'b00, 2'b00, 0, 0, 0,  0, 0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      logic [5:0] id1;
      v = tbl[i];
      id1 = v.id0 + 6'd1;
      drive(v.valid, v.excp, v.refetch, v.jump, v.stall, v.pc0, v.tgt0, v.tgt1);
      tail = v.tail;
      @(negedge clk);
      chk($sformatf("v%0d rrrid0", i), 32'(rrrid[0]), 32'(v.id0));
      chk($sformatf("v%0d rrrid1", i), 32'(rrrid[1]), 32'(id1));
      chk($sformatf("v%0d retire", i), 32'(ret), 32'(v.ret));
      chk($sformatf("v%0d wb_en", i), 32'(wb), 32'(v.wb));
      chk($sformatf("v%0d stall_dispatch", i), 32'(sd), 32'(v.sd));
      chk($sformatf("v%0d flush", i), 32'(fl), 32'(v.fl));
      chk($sformatf("v%0d redirect", i), 32'(rd), 32'(v.fl));
      chk($sformatf("v%0d excp", i), 32'(ex), 32'(v.ex));
      if (v.fl) chk($sformatf("v%0d redirect_pc", i), rpc, v.rpc);
      if (v.ex) chk($sformatf("v%0d excp_pc", i), epc, v.epc);
      next_cycle();
    end

    // Wrap and full walk on the small instance: head reaches 6, tail 2 -> 4 entries.
    do_reset();
    drive(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 32'h1000, T0, 32'h0);
    @(negedge clk); chk("wrap r0", 32'(ret2), 32'd3);
    next_cycle();
    @(negedge clk); chk("wrap r1 id0", 32'(rrrid2[0]), 32'd2);
    next_cycle();
    drive(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 32'h1000, T0, 32'h0);
    @(negedge clk); chk("wrap r2 id0", 32'(rrrid2[0]), 32'd0);
    next_cycle();
    drive(2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 32'h1000, T0, 32'h0);
    tail2 = 3'd2;
    @(negedge clk);
    chk("wrap ev id0", 32'(rrrid2[0]), 32'd1);
    chk("wrap ev retire", 32'(ret2), 32'd1);
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h1000, 32'h0, 32'h0);
    @(negedge clk);
    chk("walk1 id0", 32'(rrrid2[0]), 32'd2);
    chk("walk1 id1", 32'(rrrid2[1]), 32'd3);
    chk("walk1 retire", 32'(ret2), 32'd3);
    chk("walk1 wb", 32'(wb2), 32'd0);
    chk("walk1 stall_dispatch", 32'(sd2), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("walk2 id0", 32'(rrrid2[0]), 32'd0);
    chk("walk2 id1", 32'(rrrid2[1]), 32'd1);
    chk("walk2 retire", 32'(ret2), 32'd3);
    next_cycle();
    @(negedge clk);
    chk("walk3 retire", 32'(ret2), 32'd0);
    chk("walk3 flush", 32'(fl2), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("wrap flush", 32'(fl2), 32'd1);
    chk("wrap redirect", 32'(rd2), 32'd1);
    chk("wrap redirect_pc", rpc2, T0);
    chk("wrap excp", 32'(ex2), 32'd0);
    next_cycle();

    // Reset while walking: back to RUN at head 0, no flush pulse, registers cleared.
    do_reset();
    drive(2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 32'h1000, T0, 32'h0);
    tail = 7'd10;
    @(negedge clk); chk("rw event retire", 32'(ret), 32'd1);
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h1000, T0, 32'h0);
    @(negedge clk);
    chk("rw walk retire", 32'(ret), 32'd3);
    chk("rw walk stall_dispatch", 32'(sd), 32'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk); chk("rw in-reset flush", 32'(fl), 32'd0);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rw c%0d flush", k), 32'(fl), 32'd0);
      chk($sformatf("rw c%0d stall_dispatch", k), 32'(sd), 32'd0);
      chk($sformatf("rw c%0d rrrid0", k), 32'(rrrid[0]), 32'd0);
      chk($sformatf("rw c%0d retire", k), 32'(ret), 32'd0);
      if (k == 0) begin
        chk("rw redirect_pc", rpc, 32'd0);
        chk("rw excp_pc", epc, 32'd0);
      end
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
